// File: rtl/half_adder_pkg.sv
// Shared defaults and helpers for the half_adder block.
// The HALF_ADDER_CHECK_EN build option is consumed by half_adder.sv only.
package half_adder_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int DEFAULT_CNT_W = 16;

    // Saturation ceiling for a counter w bits wide (all ones, up to 64 bits).
    function automatic logic [63:0] cnt_max(input int unsigned w);
        logic [63:0] val;
        val = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < w) begin
                val[i] = 1'b1;
            end
        end
        return val;
    endfunction

    localparam logic [DEFAULT_CNT_W-1:0] DEFAULT_CNT_MAX = DEFAULT_CNT_W'(cnt_max(DEFAULT_CNT_W));

endpackage

// File: rtl/half_adder_lane.sv
// One combinational half-adder lane: sum and carry of two single bits.
// Instantiated once per lane by half_adder.
module half_adder_lane
    import half_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/half_adder.sv
// Registered multi-lane half adder with a saturating carry-event counter.
// Define HALF_ADDER_CHECK_EN to build the sticky S+2C == X+Y self-checker driving err.
module half_adder
    import half_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             clr_cnt,
    output logic             out_valid,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] C,
    output logic [CNT_W-1:0] carry_cnt,
    output logic             err
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic [WIDTH-1:0] sum_comb;
    logic [WIDTH-1:0] carry_comb;

    logic [WIDTH-1:0] s_reg, s_next;
    logic [WIDTH-1:0] c_reg, c_next;
    logic             valid_reg, valid_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            half_adder_lane u_lane (
                .a (X[gi]),
                .b (Y[gi]),
                .s (sum_comb[gi]),
                .c (carry_comb[gi])
            );
        end
    endgenerate

    // Clear overrides a same-cycle increment; the counter sticks at all-ones.
    always_comb begin
        s_next     = s_reg;
        c_next     = c_reg;
        valid_next = in_valid;
        cnt_next   = cnt_reg;
        if (in_valid) begin
            s_next = sum_comb;
            c_next = carry_comb;
            if ((|carry_comb) && (cnt_reg != CNT_MAX)) begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
        if (clr_cnt) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_reg     <= '0;
            c_reg     <= '0;
            valid_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            s_reg     <= s_next;
            c_reg     <= c_next;
            valid_reg <= valid_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign S         = s_reg;
    assign C         = c_reg;
    assign out_valid = valid_reg;
    assign carry_cnt = cnt_reg;

`ifdef HALF_ADDER_CHECK_EN
    // Keep a copy of the accepted operands so the registered result can be
    // re-added arithmetically and compared lane by lane.
    logic [WIDTH-1:0] x_reg, x_next;
    logic [WIDTH-1:0] y_reg, y_next;
    logic [WIDTH-1:0] lane_bad;
    logic             err_reg, err_next;

    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_check
            assign lane_bad[gi] =
                ({1'b0, s_reg[gi]} + {c_reg[gi], 1'b0}) !=
                ({1'b0, x_reg[gi]} + {1'b0, y_reg[gi]});
        end
    endgenerate

    always_comb begin
        x_next   = x_reg;
        y_next   = y_reg;
        err_next = err_reg;
        if (in_valid) begin
            x_next = X;
            y_next = Y;
        end
        if (valid_reg && (|lane_bad)) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_reg   <= '0;
            y_reg   <= '0;
            err_reg <= 1'b0;
        end else begin
            x_reg   <= x_next;
            y_reg   <= y_next;
            err_reg <= err_next;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Scoreboard bench for half_adder (WIDTH=4, CNT_W=2) driven by a directed
// vector table whose expected outputs are written out by hand.
module tb_half_adder;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             clr_cnt;
    logic             out_valid;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] C;
    logic [CNT_W-1:0] carry_cnt;
    logic             err;

    half_adder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .X         (X),
        .Y         (Y),
        .clr_cnt   (clr_cnt),
        .out_valid (out_valid),
        .S         (S),
        .C         (C),
        .carry_cnt (carry_cnt),
        .err       (err)
    );

    typedef struct {
        logic       rst_n;
        logic       v;
        logic       clr;
        logic [3:0] x;
        logic [3:0] y;
        logic       ov;
        logic [3:0] s;
        logic [3:0] c;
        logic [1:0] cnt;
    } vec_t;

    typedef struct {
        int         due;
        int         idx;
        logic       ov;
        logic [3:0] s;
        logic [3:0] c;
        logic [1:0] cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic add(input logic r, input logic v, input logic cl,
                       input logic [3:0] x, input logic [3:0] y,
                       input logic ov, input logic [3:0] s, input logic [3:0] c,
                       input logic [1:0] cnt);
        vec_t t;
        t.rst_n = r; t.v = v; t.clr = cl; t.x = x; t.y = y;
        t.ov = ov; t.s = s; t.c = c; t.cnt = cnt;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s txn %0d: got %h expected %h", name, idx, act, req);
        end
    endtask

    // Monitor: compare every scoreboard entry due on the edge just passed.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                e = sb_q.pop_front();
                $display("txn %0d: out_valid=%0b S=%h C=%h carry_cnt=%0d err=%0b",
                         e.idx, out_valid, S, C, carry_cnt, err);
                chk("out_valid", e.idx, {3'b0, out_valid}, {3'b0, e.ov});
                chk("S",         e.idx, S, e.s);
                chk("C",         e.idx, C, e.c);
                chk("carry_cnt", e.idx, {2'b0, carry_cnt}, {2'b0, e.cnt});
                chk("err",       e.idx, {3'b0, err}, 4'h0);
            end
        end
    end

    initial begin
        exp_t e;
        rst_n = 1'b0; in_valid = 1'b0; clr_cnt = 1'b0; X = '0; Y = '0;

        //  rst v clr  X     Y      ov S     C     cnt
        add(0, 1, 0, 4'hf, 4'hf,  0, 4'h0, 4'h0, 2'd0);  // inputs in reset cycle dropped
        add(0, 0, 0, 4'h0, 4'h0,  0, 4'h0, 4'h0, 2'd0);
        add(1, 1, 0, 4'h0, 4'h0,  1, 4'h0, 4'h0, 2'd0);  // single-lane truth table
        add(1, 1, 0, 4'h0, 4'h1,  1, 4'h1, 4'h0, 2'd0);
        add(1, 1, 0, 4'h1, 4'h0,  1, 4'h1, 4'h0, 2'd0);
        add(1, 1, 0, 4'h1, 4'h1,  1, 4'h0, 4'h1, 2'd1);
        add(1, 1, 0, 4'h1, 4'h1,  1, 4'h0, 4'h1, 2'd2);  // then hold for 3 idle cycles
        add(1, 0, 0, 4'h5, 4'h3,  0, 4'h0, 4'h1, 2'd2);
        add(1, 0, 0, 4'h5, 4'h3,  0, 4'h0, 4'h1, 2'd2);
        add(1, 0, 0, 4'h5, 4'h3,  0, 4'h0, 4'h1, 2'd2);
        add(1, 1, 1, 4'h1, 4'h1,  1, 4'h0, 4'h1, 2'd0);  // clear beats increment
        add(1, 1, 0, 4'hb, 4'h6,  1, 4'hd, 4'h2, 2'd1);  // 1011 + 0110 per lane
        add(1, 0, 1, 4'h0, 4'h0,  0, 4'hd, 4'h2, 2'd0);  // clear while idle
        add(1, 1, 0, 4'h1, 4'h1,  1, 4'h0, 4'h1, 2'd1);  // saturation 1,2,3,3,3
        add(1, 1, 0, 4'h1, 4'h1,  1, 4'h0, 4'h1, 2'd2);
        add(1, 1, 0, 4'hf, 4'hf,  1, 4'h0, 4'hf, 2'd3);
        add(1, 1, 0, 4'hf, 4'hf,  1, 4'h0, 4'hf, 2'd3);
        add(1, 1, 0, 4'hf, 4'hf,  1, 4'h0, 4'hf, 2'd3);
        add(1, 1, 0, 4'ha, 4'h5,  1, 4'hf, 4'h0, 2'd3);
        add(1, 1, 1, 4'ha, 4'h5,  1, 4'hf, 4'h0, 2'd0);
        add(1, 1, 0, 4'hc, 4'h3,  1, 4'hf, 4'h0, 2'd0);  // no carry, no count
        add(1, 1, 0, 4'h8, 4'h8,  1, 4'h0, 4'h8, 2'd1);  // top lane carry stays in lane
        add(1, 1, 0, 4'h3, 4'h1,  1, 4'h2, 4'h1, 2'd2);
        add(0, 1, 1, 4'hf, 4'hf,  0, 4'h0, 4'h0, 2'd0);  // mid-stream reset wins
        add(1, 1, 0, 4'h1, 4'h1,  1, 4'h0, 4'h1, 2'd1);  // first result after reset
        add(1, 0, 0, 4'h0, 4'h0,  0, 4'h0, 4'h1, 2'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            rst_n    = vecs[i].rst_n;
            in_valid = vecs[i].v;
            clr_cnt  = vecs[i].clr;
            X        = vecs[i].x;
            Y        = vecs[i].y;
            e.due = cyc + 1;
            e.idx = i;
            e.ov  = vecs[i].ov;
            e.s   = vecs[i].s;
            e.c   = vecs[i].c;
            e.cnt = vecs[i].cnt;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr_cnt  = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/half_adder.md
HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 Parameter WIDTH, default 1: number of independent one-bit half-adder lanes.
REQ-002 Parameter CNT_W, default 16: width of the carry-event counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  X/Y are sampled this cycle when high.
REQ-006 X  input  WIDTH  addend A, one bit per lane.
REQ-007 Y  input  WIDTH  addend B, one bit per lane.
REQ-008 clr_cnt  input  1  synchronous clear of carry_cnt.
REQ-009 out_valid  output  1  S/C hold a freshly computed result.
REQ-010 S  output  WIDTH  registered sum per lane.
REQ-011 C  output  WIDTH  registered carry per lane.
REQ-012 carry_cnt  output  CNT_W  saturating count of accepted vectors with any carry set.
REQ-013 err  output  1  sticky self-check error flag, see Configuration.

Function
REQ-014 Per lane i, on an accepted cycle (in_valid=1), S[i] SHALL become X[i] XOR Y[i] and C[i] SHALL become X[i] AND Y[i].
REQ-015 Latency SHALL be exactly one clock: result visible the cycle after sampling.
REQ-016 out_valid SHALL equal in_valid delayed by one clock.
REQ-017 When in_valid=0, S and C SHALL hold their previous values.
REQ-018 Lanes SHALL be fully independent, with no carry between lanes.
REQ-019 carry_cnt SHALL increment by 1 on each accepted cycle where (X AND Y) is non-zero.
REQ-020 carry_cnt SHALL saturate at all-ones and never wrap.
REQ-021 If clr_cnt=1 in the same cycle as an increment, the clear SHALL win and carry_cnt SHALL become 0.
REQ-022 There SHALL be no backpressure: every in_valid cycle is accepted.

Reset
REQ-023 rst_n=0 sampled at a clock edge SHALL set S=0, C=0, out_valid=0, carry_cnt=0 and err=0.
REQ-024 Reset SHALL take priority over in_valid and clr_cnt.
REQ-025 Any input sampled in the reset cycle SHALL be discarded.
REQ-026 The first valid result SHALL appear one clock after the first accepted cycle with rst_n=1.

Configuration
REQ-027 Macro HALF_ADDER_CHECK_EN defined: an internal checker on each out_valid cycle SHALL verify, per lane, S+2*C equals the registered X+Y. On mismatch, err SHALL set and stay set until reset.
REQ-028 Macro HALF_ADDER_CHECK_EN undefined: the checker logic SHALL be absent and err SHALL be tied to 0. The port list is identical in both builds.

Structure
REQ-029 Package half_adder_pkg SHALL hold the default WIDTH and CNT_W constants and the saturating-max helper constant.
REQ-030 Sub-module half_adder_lane (purely combinational, 1-bit a,b -> s,c) SHALL be instantiated WIDTH times. Registers, counter and checker SHALL live in half_adder.

Verification
REQ-031 WIDTH=1, after reset, apply X/Y = 00,01,10,11 on consecutive valid cycles -> S/C = 0/0, 1/0, 1/0, 0/1, each one cycle later; carry_cnt=1 at the end.
REQ-032 Valid 11, then in_valid=0 for 3 cycles -> S=0, C=1 held, out_valid=0, carry_cnt unchanged.
REQ-033 WIDTH=4, X=4'b1011, Y=4'b0110 -> S=4'b1101, C=4'b0010; carry_cnt increments by 1.
REQ-034 CNT_W=2, five valid cycles of 11 -> carry_cnt reads 1,2,3,3,3.
REQ-035 clr_cnt=1 together with valid 11 while carry_cnt=2 -> carry_cnt=0 next cycle; S=0, C=1.
REQ-036 rst_n=0 asserted mid-stream with valid 11 -> next cycle all outputs 0; with HALF_ADDER_CHECK_EN defined, err stays 0 through an exhaustive run.
